// File: rtl/stage_mem_sized.sv
// MIPS MEM stage: sized load/store against an internal word RAM, optional
// wait states with a stall back to the pipeline, misaligned-access detection,
// and the MEM/WB pipeline register (including the registered branch decision).
module stage_mem_sized #(
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned WR_W        = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            regWriteIn,
  input  logic            memToRegIn,
  input  logic            memWriteIn,
  input  logic            memReadIn,
  input  logic            branchIn,
  input  logic            zero,
  input  logic [1:0]      accSize,
  input  logic            loadUnsigned,
  input  logic [31:0]     aluResultIn,
  input  logic [31:0]     writeDataIn,
  input  logic [WR_W-1:0] wrIn,
  output logic            regWriteOut,
  output logic            memToRegOut,
  output logic [31:0]     readDataOut,
  output logic [31:0]     aluResultOut,
  output logic [WR_W-1:0] wrOut,
  output logic            PCSrcOut,
  output logic            misalignOut,
  output logic            stallOut
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           ram [DEPTH];
  logic [DEPTH_LOG2-1:0] wordIdx;
  logic [1:0]            byteOff;
  logic [3:0]            cnt;
  logic                  memAccess;
  logic                  misaligned;
  logic                  req;
  logic                  done;
  logic [31:0]           ramWord;
  logic [31:0]           storeWord;
  logic [31:0]           loadData;
  logic [7:0]            loadByte;
  logic [15:0]           loadHalf;

  // Higher address bits are dropped, so the RAM wraps.
  assign wordIdx = aluResultIn[DEPTH_LOG2+1:2];
  assign byteOff = aluResultIn[1:0];
  assign ramWord = ram[wordIdx];

  // Alignment check and request/stall handshake.
  always_comb begin
    memAccess = memReadIn | memWriteIn;
    case (accSize)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = memAccess & byteOff[0];
      default: misaligned = memAccess & (byteOff != 2'b00);
    endcase
    req      = memAccess & ~misaligned;
    done     = req & (cnt == 4'(WAIT_STATES));
    stallOut = req & ~done;
  end

  // Lane extraction and sign/zero extension for loads.
  always_comb begin
    loadByte = 8'(ramWord >> {byteOff, 3'b000});
    loadHalf = byteOff[1] ? ramWord[31:16] : ramWord[15:0];
    case (accSize)
      2'b00:   loadData = loadUnsigned ? {24'h0, loadByte}
                                       : {{24{loadByte[7]}}, loadByte};
      2'b01:   loadData = loadUnsigned ? {16'h0, loadHalf}
                                       : {{16{loadHalf[15]}}, loadHalf};
      default: loadData = ramWord;
    endcase
  end

  // Merge store data into the addressed word, preserving untouched lanes.
  always_comb begin
    storeWord = ramWord;
    case (accSize)
      2'b00:   storeWord[{byteOff, 3'b000} +: 8]     = writeDataIn[7:0];
      2'b01:   storeWord[{byteOff[1], 4'b0000} +: 16] = writeDataIn[15:0];
      default: storeWord = writeDataIn;
    endcase
  end

  // RAM write on the completion edge; an edge seen while reset is low never
  // commits, so a store interrupted by reset is dropped.
  always_ff @(posedge clk) begin
    if (reset && done && memWriteIn) begin
      ram[wordIdx] <= storeWord;
    end
  end

  // Wait-state counter: counts stalled edges, clears on completion or idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (stallOut) begin
      cnt <= cnt + 4'd1;
    end else begin
      cnt <= '0;
    end
  end

  // MEM/WB register: bubble while stalled, otherwise real (or squashed) values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regWriteOut  <= 1'b0;
      memToRegOut  <= 1'b0;
      readDataOut  <= '0;
      aluResultOut <= '0;
      wrOut        <= '0;
      PCSrcOut     <= 1'b0;
      misalignOut  <= 1'b0;
    end else if (stallOut) begin
      regWriteOut  <= 1'b0;
      memToRegOut  <= 1'b0;
      readDataOut  <= '0;
      aluResultOut <= aluResultIn;
      wrOut        <= wrIn;
      PCSrcOut     <= 1'b0;
      misalignOut  <= 1'b0;
    end else begin
      regWriteOut  <= regWriteIn & ~misaligned;
      memToRegOut  <= memToRegIn & ~misaligned;
      readDataOut  <= (done && memReadIn && !memWriteIn) ? loadData : '0;
      aluResultOut <= aluResultIn;
      wrOut        <= wrIn;
      PCSrcOut     <= branchIn & zero;
      misalignOut  <= misaligned;
    end
  end

endmodule
